wqe_queue_arbiter: RTL and testbench

- Round-robin scheduler that shares the single WQE admission port of the resource pool between NUM_Q send queues.
- Tags each granted WQE id with its queue number.
- Enforces a per-queue cap on outstanding (issued, not yet completed) WQEs by snooping the pool's completion stream.
- Sits between the per-queue WQE fetch logic and the pool's s_axis_wqe / m_axis_cpl ports.

---
 rtl/wqe_arb_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 31 +++
 rtl/wqe_queue_arbiter.sv | 140 ++++++++++++++
 tb/tb_wqe_queue_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wqe_arb_pkg.sv
// Shared types and helpers for the WQE queue arbiter: FSM state, width
// derivation and the {queue, local index} id packing used on the pool port.
package wqe_arb_pkg;

    typedef enum logic {ST_IDLE, ST_HOLD} arb_state_e;

    function automatic int q_width_f(input int num_q);
        return (num_q > 1) ? $clog2(num_q) : 1;
    endfunction

    function automatic int cnt_width_f(input int max_out);
        return $clog2(max_out + 1);
    endfunction

    // Queue tag sits above the local index; callers truncate to their id width.
    function automatic logic [31:0] pack_id(input int local_w, input logic [31:0] q,
                                            input logic [31:0] idx);
        logic [31:0] mask;
        mask = (32'd1 << local_w) - 32'd1;
        return (q << local_w) | (idx & mask);
    endfunction

    function automatic logic [31:0] unpack_q(input int local_w, input logic [31:0] id);
        return id >> local_w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps,
// producing a one-hot grant plus its encoded index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int off = 0; off < N; off++) begin
            cand = IDX_W'((int'(ptr) + off) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/wqe_queue_arbiter.sv
// Shares the pool's WQE admission port between NUM_Q send queues, tagging ids
// with the queue number and capping each queue's in-flight WQEs.
module wqe_queue_arbiter
    import wqe_arb_pkg::*;
#(
    parameter int NUM_Q           = 4,
    parameter int WQE_INDEX_WIDTH = 10,
    parameter int Q_WIDTH         = q_width_f(NUM_Q),
    parameter int LOCAL_WIDTH     = WQE_INDEX_WIDTH - Q_WIDTH,
    parameter int WQE_LEN_WIDTH   = 21,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_WIDTH       = cnt_width_f(MAX_OUTSTANDING)
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst,
    input  logic [NUM_Q-1:0]               s_axis_req_valid,
    input  logic [NUM_Q*LOCAL_WIDTH-1:0]   s_axis_req_idx,
    input  logic [NUM_Q*WQE_LEN_WIDTH-1:0] s_axis_req_len,
    output logic [NUM_Q-1:0]               s_axis_req_ready,
    input  logic [NUM_Q-1:0]               queue_enable,
    output logic                           m_axis_wqe_valid,
    output logic [WQE_INDEX_WIDTH-1:0]     m_axis_wqe_id,
    output logic [WQE_LEN_WIDTH-1:0]       m_axis_wqe_len,
    input  logic                           m_axis_wqe_ready,
    input  logic                           s_axis_cpl_valid,
    input  logic [WQE_INDEX_WIDTH-1:0]     s_axis_cpl_id,
    output logic                           s_axis_cpl_ready,
    input  logic                           m_axis_cpl_ready,
    output logic                           m_axis_cpl_valid,
    output logic [WQE_INDEX_WIDTH-1:0]     m_axis_cpl_id,
    output logic [NUM_Q*CNT_WIDTH-1:0]     outstanding,
    output logic                           err_underflow
);

    logic [NUM_Q-1:0][LOCAL_WIDTH-1:0]   req_idx_a;
    logic [NUM_Q-1:0][WQE_LEN_WIDTH-1:0] req_len_a;
    logic [NUM_Q-1:0][CNT_WIDTH-1:0]     cnt;
    logic [NUM_Q-1:0]                    eligible, gnt, uflow_hit;

    arb_state_e       state;
    logic [Q_WIDTH-1:0] rr_ptr, held_q, arb_ptr, gnt_idx, cpl_q;
    logic             gnt_any, can_load, accept, wqe_hs, cpl_hs;

    assign req_idx_a = s_axis_req_idx;
    assign req_len_a = s_axis_req_len;
    assign outstanding = cnt;

    // Completion path is a pure wire-through; we only snoop the handshake.
    assign s_axis_cpl_ready = m_axis_cpl_ready;
    assign m_axis_cpl_valid = s_axis_cpl_valid;
    assign m_axis_cpl_id    = s_axis_cpl_id;
    assign cpl_hs = s_axis_cpl_valid & m_axis_cpl_ready;
    assign cpl_q  = Q_WIDTH'(unpack_q(LOCAL_WIDTH, 32'(s_axis_cpl_id)));

    // On a pool handshake the pointer advances past the delivered queue in
    // the same cycle, so back-to-back grants already see the new order.
    assign wqe_hs   = m_axis_wqe_valid & m_axis_wqe_ready;
    assign arb_ptr  = wqe_hs ? held_q + Q_WIDTH'(1) : rr_ptr;
    assign can_load = ~m_axis_wqe_valid | m_axis_wqe_ready;
    assign accept   = sys_rst & can_load & gnt_any;
    assign s_axis_req_ready = accept ? gnt : '0;

    rr_arbiter #(.N(NUM_Q), .IDX_W(Q_WIDTH)) u_rr (
        .req       (eligible),
        .ptr       (arb_ptr),
        .grant     (gnt),
        .grant_idx (gnt_idx),
        .any       (gnt_any)
    );

    for (genvar q = 0; q < NUM_Q; q++) begin : g_q
        logic                 inc, dec;
        logic [CNT_WIDTH-1:0] cnt_r;

        assign inc = s_axis_req_ready[q];
        assign dec = cpl_hs & (cpl_q == Q_WIDTH'(q));
        assign uflow_hit[q] = dec & ~inc & (cnt_r == '0);
        assign eligible[q]  = s_axis_req_valid[q] & queue_enable[q]
                            & (cnt_r < CNT_WIDTH'(MAX_OUTSTANDING));
        assign cnt[q] = cnt_r;

        always_ff @(posedge sys_clk or negedge sys_rst) begin
            if (!sys_rst)
                cnt_r <= '0;
            else if (inc & ~dec)
                cnt_r <= cnt_r + CNT_WIDTH'(1);
            else if (dec & ~inc & (cnt_r != '0))
                cnt_r <= cnt_r - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst)
            err_underflow <= 1'b0;
        else if (|uflow_hit)
            err_underflow <= 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state            <= ST_IDLE;
            m_axis_wqe_valid <= 1'b0;
            m_axis_wqe_id    <= '0;
            m_axis_wqe_len   <= '0;
            rr_ptr           <= '0;
            held_q           <= '0;
        end else begin
            if (wqe_hs)
                rr_ptr <= arb_ptr;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state            <= ST_HOLD;
                        m_axis_wqe_valid <= 1'b1;
                        m_axis_wqe_id    <= WQE_INDEX_WIDTH'(pack_id(LOCAL_WIDTH,
                                            32'(gnt_idx), 32'(req_idx_a[gnt_idx])));
                        m_axis_wqe_len   <= req_len_a[gnt_idx];
                        held_q           <= gnt_idx;
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        m_axis_wqe_id  <= WQE_INDEX_WIDTH'(pack_id(LOCAL_WIDTH,
                                          32'(gnt_idx), 32'(req_idx_a[gnt_idx])));
                        m_axis_wqe_len <= req_len_a[gnt_idx];
                        held_q         <= gnt_idx;
                    end else if (wqe_hs) begin
                        state            <= ST_IDLE;
                        m_axis_wqe_valid <= 1'b0;
                    end
                end
                default: begin
                    state            <= ST_IDLE;
                    m_axis_wqe_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wqe_queue_arbiter.sv
// Directed bench for wqe_queue_arbiter (4 queues, cap of 2 in flight per queue).
module tb_wqe_queue_arbiter;

    localparam int NQ   = 4;
    localparam int LW   = 8;
    localparam int IW   = 10;
    localparam int LENW = 21;
    localparam int CW   = 2;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst = 1'b0;
    logic [NQ-1:0]        s_axis_req_valid;
    logic [NQ*LW-1:0]     s_axis_req_idx;
    logic [NQ*LENW-1:0]   s_axis_req_len;
    logic [NQ-1:0]        s_axis_req_ready;
    logic [NQ-1:0]        queue_enable;
    logic                 m_axis_wqe_valid;
    logic [IW-1:0]        m_axis_wqe_id;
    logic [LENW-1:0]      m_axis_wqe_len;
    logic                 m_axis_wqe_ready;
    logic                 s_axis_cpl_valid;
    logic [IW-1:0]        s_axis_cpl_id;
    logic                 s_axis_cpl_ready;
    logic                 m_axis_cpl_ready;
    logic                 m_axis_cpl_valid;
    logic [IW-1:0]        m_axis_cpl_id;
    logic [NQ*CW-1:0]     outstanding;
    logic                 err_underflow;

    int n_chk  = 0;
    int n_fail = 0;
    int grants;

    wqe_queue_arbiter #(.NUM_Q(NQ), .WQE_INDEX_WIDTH(IW), .WQE_LEN_WIDTH(LENW),
                        .MAX_OUTSTANDING(2)) dut (
        .sys_clk          (sys_clk),
        .sys_rst          (sys_rst),
        .s_axis_req_valid (s_axis_req_valid),
        .s_axis_req_idx   (s_axis_req_idx),
        .s_axis_req_len   (s_axis_req_len),
        .s_axis_req_ready (s_axis_req_ready),
        .queue_enable     (queue_enable),
        .m_axis_wqe_valid (m_axis_wqe_valid),
        .m_axis_wqe_id    (m_axis_wqe_id),
        .m_axis_wqe_len   (m_axis_wqe_len),
        .m_axis_wqe_ready (m_axis_wqe_ready),
        .s_axis_cpl_valid (s_axis_cpl_valid),
        .s_axis_cpl_id    (s_axis_cpl_id),
        .s_axis_cpl_ready (s_axis_cpl_ready),
        .m_axis_cpl_ready (m_axis_cpl_ready),
        .m_axis_cpl_valid (m_axis_cpl_valid),
        .m_axis_cpl_id    (m_axis_cpl_id),
        .outstanding      (outstanding),
        .err_underflow    (err_underflow)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [3:0] req_valid;
        logic [3:0] enable;
        logic       wqe_ready;
        logic       cpl_valid;
        logic [9:0] cpl_id;
        logic [3:0] exp_ready;
        logic       exp_valid;
        logic [9:0] exp_id;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        sys_rst          = 1'b0;
        s_axis_req_valid = 4'hF;
        queue_enable     = 4'hF;
        m_axis_wqe_ready = 1'b0;
        s_axis_cpl_valid = 1'b0;
        s_axis_cpl_id    = '0;
        m_axis_cpl_ready = 1'b1;
        s_axis_req_idx   = {8'h13, 8'h12, 8'h11, 8'h10};
        s_axis_req_len   = {21'd103, 21'd102, 21'd101, 21'd100};
        @(negedge sys_clk);
        chk("rst_ready", 32'(s_axis_req_ready), 32'h0);
        chk("rst_valid", 32'(m_axis_wqe_valid), 32'h0);
        chk("rst_id",    32'(m_axis_wqe_id), 32'h0);
        chk("rst_len",   32'(m_axis_wqe_len), 32'h0);
        chk("rst_out",   32'(outstanding), 32'h0);
        chk("rst_err",   32'(err_underflow), 32'h0);
        s_axis_req_valid = 4'h0;
        step();
        sys_rst = 1'b1;
    endtask

    initial begin
        //          valid  en    wr    cv    cid     rdy    vld   id      out
        vecs[0]  = '{4'hF, 4'hF, 1'b1, 1'b0, 10'h0,   4'b0001, 1'b0, 10'h000, 8'h00};
        vecs[1]  = '{4'hF, 4'hF, 1'b1, 1'b0, 10'h0,   4'b0010, 1'b1, 10'h010, 8'h01};
        vecs[2]  = '{4'hF, 4'hF, 1'b1, 1'b0, 10'h0,   4'b0100, 1'b1, 10'h111, 8'h05};
        vecs[3]  = '{4'hF, 4'hF, 1'b1, 1'b0, 10'h0,   4'b1000, 1'b1, 10'h212, 8'h15};
        vecs[4]  = '{4'hF, 4'hF, 1'b1, 1'b0, 10'h0,   4'b0001, 1'b1, 10'h313, 8'h55};
        vecs[5]  = '{4'hF, 4'hF, 1'b1, 1'b0, 10'h0,   4'b0010, 1'b1, 10'h010, 8'h56};
        vecs[6]  = '{4'hF, 4'hF, 1'b1, 1'b0, 10'h0,   4'b0100, 1'b1, 10'h111, 8'h5A};
        vecs[7]  = '{4'hF, 4'hF, 1'b1, 1'b0, 10'h0,   4'b1000, 1'b1, 10'h212, 8'h6A};
        vecs[8]  = '{4'hF, 4'hF, 1'b1, 1'b0, 10'h0,   4'b0000, 1'b1, 10'h313, 8'hAA};
        vecs[9]  = '{4'hF, 4'hF, 1'b1, 1'b1, 10'h111, 4'b0000, 1'b0, 10'h313, 8'hAA};
        vecs[10] = '{4'hF, 4'hF, 1'b1, 1'b0, 10'h0,   4'b0010, 1'b0, 10'h313, 8'hA6};
        vecs[11] = '{4'hF, 4'hF, 1'b1, 1'b0, 10'h0,   4'b0000, 1'b1, 10'h111, 8'hAA};

        // Round-robin over all queues until every queue hits its cap, then drain one.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            s_axis_req_valid = vecs[i].req_valid;
            queue_enable     = vecs[i].enable;
            m_axis_wqe_ready = vecs[i].wqe_ready;
            s_axis_cpl_valid = vecs[i].cpl_valid;
            s_axis_cpl_id    = vecs[i].cpl_id;
            @(negedge sys_clk);
            chk($sformatf("v%0d_ready", i), 32'(s_axis_req_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("v%0d_valid", i), 32'(m_axis_wqe_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_id", i),    32'(m_axis_wqe_id),    32'(vecs[i].exp_id));
            chk($sformatf("v%0d_out", i),   32'(outstanding),      32'(vecs[i].exp_out));
            step();
        end

        // Single queue 2 request: tag in id MSBs, length forwarded.
        do_reset();
        s_axis_req_idx[2*LW +: LW]     = 8'h15;
        s_axis_req_len[2*LENW +: LENW] = 21'd4097;
        s_axis_req_valid = 4'b0100;
        m_axis_wqe_ready = 1'b1;
        @(negedge sys_clk);
        chk("q2_ready", 32'(s_axis_req_ready), 32'b0100);
        step();
        s_axis_req_valid = 4'b0000;
        @(negedge sys_clk);
        chk("q2_valid", 32'(m_axis_wqe_valid), 32'h1);
        chk("q2_id",    32'(m_axis_wqe_id), 32'h215);
        chk("q2_len",   32'(m_axis_wqe_len), 32'd4097);
        chk("q2_out",   32'(outstanding[2*CW +: CW]), 32'd1);
        step();

        // Cap: queue 1 always valid gets exactly two grants until a completion.
        do_reset();
        s_axis_req_valid = 4'b0010;
        m_axis_wqe_ready = 1'b1;
        grants = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge sys_clk);
            if (s_axis_req_ready[1]) grants++;
            step();
        end
        chk("cap_grants", 32'(grants), 32'd2);
        s_axis_cpl_valid = 1'b1;
        s_axis_cpl_id    = 10'h1AB;
        @(negedge sys_clk);
        chk("cap_blocked", 32'(s_axis_req_ready), 32'h0);
        step();
        s_axis_cpl_valid = 1'b0;
        @(negedge sys_clk);
        chk("cap_regrant", 32'(s_axis_req_ready), 32'b0010);
        chk("cap_out1",    32'(outstanding[1*CW +: CW]), 32'd1);
        step();
        @(negedge sys_clk);
        chk("cap_out2",    32'(outstanding[1*CW +: CW]), 32'd2);
        step();

        // Backpressure: held output stable, no further accepts while stalled.
        do_reset();
        s_axis_req_valid = 4'b1001;
        @(negedge sys_clk);
        chk("bp_first", 32'(s_axis_req_ready), 32'b0001);
        step();
        for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            chk($sformatf("bp%0d_ready", c), 32'(s_axis_req_ready), 32'h0);
            chk($sformatf("bp%0d_id", c),    32'(m_axis_wqe_id), 32'h010);
            chk($sformatf("bp%0d_valid", c), 32'(m_axis_wqe_valid), 32'h1);
            step();
        end
        m_axis_wqe_ready = 1'b1;
        @(negedge sys_clk);
        chk("bp_next", 32'(s_axis_req_ready), 32'b1000);
        step();
        // Disabled queues: the held WQE still drains, nothing new is granted.
        m_axis_wqe_ready = 1'b0;
        queue_enable     = 4'b0000;
        @(negedge sys_clk);
        chk("dis_id", 32'(m_axis_wqe_id), 32'h313);
        step();
        m_axis_wqe_ready = 1'b1;
        @(negedge sys_clk);
        chk("dis_ready", 32'(s_axis_req_ready), 32'h0);
        chk("dis_valid", 32'(m_axis_wqe_valid), 32'h1);
        step();
        @(negedge sys_clk);
        chk("dis_drained", 32'(m_axis_wqe_valid), 32'h0);
        chk("dis_out",     32'(outstanding), 32'h41);
        step();

        // Same-cycle accept and completion for queue 0, then underflow on queue 3.
        do_reset();
        s_axis_req_valid = 4'b0001;
        m_axis_wqe_ready = 1'b1;
        step();
        s_axis_cpl_valid = 1'b1;
        s_axis_cpl_id    = 10'h0A5;
        @(negedge sys_clk);
        chk("same_ready", 32'(s_axis_req_ready), 32'b0001);
        step();
        s_axis_req_valid = 4'b0000;
        s_axis_cpl_id    = 10'h300;
        @(negedge sys_clk);
        chk("same_out0", 32'(outstanding[1:0]), 32'd1);
        chk("cpl_pass_v",  32'(m_axis_cpl_valid), 32'h1);
        chk("cpl_pass_id", 32'(m_axis_cpl_id), 32'h300);
        chk("cpl_rdy",     32'(s_axis_cpl_ready), 32'h1);
        chk("uf_pre",      32'(err_underflow), 32'h0);
        step();
        s_axis_cpl_valid = 1'b0;
        @(negedge sys_clk);
        chk("uf_err",  32'(err_underflow), 32'h1);
        chk("uf_out3", 32'(outstanding[7:6]), 32'd0);
        step();
        @(negedge sys_clk);
        chk("uf_sticky", 32'(err_underflow), 32'h1);

        // Reset mid-HOLD after the pointer has moved off queue 0.
        do_reset();
        s_axis_req_valid = 4'hF;
        m_axis_wqe_ready = 1'b1;
        step();
        step();
        m_axis_wqe_ready = 1'b0;
        #2;
        chk("mid_hold", 32'(m_axis_wqe_valid), 32'h1);
        sys_rst = 1'b0;
        #1;
        chk("arst_valid", 32'(m_axis_wqe_valid), 32'h0);
        chk("arst_out",   32'(outstanding), 32'h0);
        chk("arst_ready", 32'(s_axis_req_ready), 32'h0);
        step();
        sys_rst = 1'b1;
        m_axis_wqe_ready = 1'b1;
        @(negedge sys_clk);
        chk("arst_restart", 32'(s_axis_req_ready), 32'b0001);
        step();
        @(negedge sys_clk);
        chk("arst_id", 32'(m_axis_wqe_id), 32'h010);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
